// File: rtl/spi_flash_responder.sv
// SPI-NOR flash responder: oversamples csn/sck/sdi, decodes READ/RDID/RDSR and serves an internal byte array.
// Define SPI_RESP_PROGRAM_EN to add WREN/WRDI/PP with a WIP busy timer.
module spi_flash_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int unsigned PROG_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csn,
    input  logic              sck,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_oe,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_wdata,
    output logic [7:0]        opcode_o,
    output logic              cmd_done
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam logic [7:0]  OP_READ = 8'h03;
    localparam logic [7:0]  OP_RDID = 8'h9F;
    localparam logic [7:0]  OP_RDSR = 8'h05;
    localparam logic [7:0]  OP_PP   = 8'h02;

    typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DOUT, DIN, IGNORE} state_t;

    state_t            state, state_next;
    logic [1:0]        csn_s, sck_s, sdi_s;
    logic              csn_q, sck_q;
    logic              csn_rise, csn_fall, sck_rise, sck_fall, sdi_bit, byte_end;
    logic [6:0]        shift_in;
    logic [7:0]        rx_byte, tx_sh, read_byte, status, id_byte;
    logic [2:0]        bit_cnt;
    logic [1:0]        addr_byte, rd_idx;
    logic [ADDR_W-1:0] addr, addr_next, rd_addr;
    logic              op_seen, wel, wip, prog_we;
    logic [7:0]        mem [DEPTH];

    // Two-stage synchronizers plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csn_s <= 2'b11;
            csn_q <= 1'b1;
            sck_s <= 2'b00;
            sck_q <= 1'b0;
            sdi_s <= 2'b00;
        end else begin
            csn_s <= {csn_s[0], csn};
            csn_q <= csn_s[1];
            sck_s <= {sck_s[0], sck};
            sck_q <= sck_s[1];
            sdi_s <= {sdi_s[0], sdi};
        end
    end

    assign csn_rise  = csn_s[1] & ~csn_q;
    assign csn_fall  = ~csn_s[1] & csn_q;
    assign sck_rise  = sck_s[1] & ~sck_q & ~csn_s[1];
    assign sck_fall  = ~sck_s[1] & sck_q & ~csn_s[1];
    assign sdi_bit   = sdi_s[1];
    assign rx_byte   = {shift_in, sdi_bit};
    assign byte_end  = sck_rise && (bit_cnt == 3'd7);
    assign addr_next = {addr[ADDR_W-2:0], sdi_bit};
    // The final address bit is still in flight when the first READ byte is fetched
    assign rd_addr   = (state == ADDR) ? addr_next : addr;
    assign read_byte = wip ? 8'hFF : mem[rd_addr];
    assign status    = {6'b0, wel, wip};

    always_comb begin
        case (rd_idx)
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (csn_s[1]) begin
            state_next = IDLE;
        end else if (state == IDLE) begin
            if (csn_fall) state_next = OPCODE;
        end else if (byte_end) begin
            case (state)
                OPCODE: begin
                    state_next = IGNORE;
                    if (rx_byte == OP_READ)
                        state_next = ADDR;
                    else if (rx_byte == OP_RDID || rx_byte == OP_RDSR)
                        state_next = DOUT;
`ifdef SPI_RESP_PROGRAM_EN
                    else if (rx_byte == OP_PP && wel && !wip)
                        state_next = ADDR;
`endif
                end
                ADDR: if (addr_byte == 2'd2) state_next = (opcode_o == OP_PP) ? DIN : DOUT;
                default: ;
            endcase
        end
    end

    // Shift, address and response datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_in  <= '0;
            bit_cnt   <= '0;
            addr_byte <= '0;
            rd_idx    <= '0;
            addr      <= '0;
            tx_sh     <= '0;
            sdo       <= 1'b0;
            sdo_oe    <= 1'b0;
            opcode_o  <= 8'h00;
            cmd_done  <= 1'b0;
            op_seen   <= 1'b0;
        end else begin
            cmd_done <= csn_rise & op_seen;
            sdo_oe   <= (state_next == DOUT);
            if (state == IDLE) begin
                bit_cnt   <= '0;
                addr_byte <= '0;
                op_seen   <= 1'b0;
            end
            if (sck_rise && state != IDLE) begin
                shift_in <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (state == ADDR) addr <= addr_next;
                if (bit_cnt == 3'd7) begin
                    case (state)
                        OPCODE: begin
                            opcode_o <= rx_byte;
                            op_seen  <= 1'b1;
                            if (rx_byte == OP_RDID) begin
                                tx_sh  <= JEDEC_ID[23:16];
                                rd_idx <= 2'd1;
                            end else if (rx_byte == OP_RDSR) begin
                                tx_sh <= status;
                            end
                        end
                        ADDR: begin
                            addr_byte <= addr_byte + 2'd1;
                            if (addr_byte == 2'd2 && opcode_o == OP_READ) begin
                                tx_sh <= read_byte;
                                addr  <= addr_next + ADDR_W'(1);
                            end
                        end
                        DOUT: begin
                            case (opcode_o)
                                OP_READ: begin
                                    tx_sh <= read_byte;
                                    addr  <= addr + ADDR_W'(1);
                                end
                                OP_RDID: begin
                                    tx_sh <= id_byte;
                                    if (rd_idx != 2'd3) rd_idx <= rd_idx + 2'd1;
                                end
                                OP_RDSR: tx_sh <= status;
                                default: tx_sh <= 8'h00;
                            endcase
                        end
                        // Page program wraps inside the current 256-byte page
                        DIN: addr[7:0] <= addr[7:0] + 8'd1;
                        default: ;
                    endcase
                end
            end
            if (sck_fall && state == DOUT) begin
                sdo   <= tx_sh[7];
                tx_sh <= {tx_sh[6:0], 1'b0};
            end
        end
    end

`ifdef SPI_RESP_PROGRAM_EN
    localparam int unsigned CNT_W   = $clog2(PROG_CYCLES + 1);
    localparam logic [7:0]  OP_WREN = 8'h06;
    localparam logic [7:0]  OP_WRDI = 8'h04;

    logic             pp_armed;
    logic [CNT_W-1:0] wip_cnt;

    assign prog_we = byte_end && (state == DIN);

    // Write-enable latch and post-program busy timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wel      <= 1'b0;
            wip      <= 1'b0;
            wip_cnt  <= '0;
            pp_armed <= 1'b0;
        end else begin
            if (byte_end && state == OPCODE) begin
                if (rx_byte == OP_WREN)      wel      <= 1'b1;
                else if (rx_byte == OP_WRDI) wel      <= 1'b0;
                else if (rx_byte == OP_PP)   pp_armed <= wel & ~wip;
            end
            if (csn_rise) pp_armed <= 1'b0;
            if (csn_rise && pp_armed) begin
                wel     <= 1'b0;
                wip     <= 1'b1;
                wip_cnt <= CNT_W'(PROG_CYCLES);
            end else if (wip) begin
                wip_cnt <= wip_cnt - CNT_W'(1);
                if (wip_cnt == CNT_W'(1)) wip <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    assign wel        = 1'b0;
    assign wip        = 1'b0;
    assign prog_we    = 1'b0;
    assign unused_cfg = ^PROG_CYCLES;
`endif

    // Byte array; SPI program write wins over preload in the same cycle
    always_ff @(posedge clk) begin
        if (prog_we)     mem[addr] <= mem[addr] & rx_byte;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: RDID, READ wrap, abort, program/WIP, reset mid-read.
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csn = 1'b1;
    logic        sck = 1'b0;
    logic        sdi = 1'b0;
    logic        mem_we = 1'b0;
    logic [11:0] mem_addr = '0;
    logic [7:0]  mem_wdata = '0;
    logic        sdo, sdo_oe, cmd_done;
    logic [7:0]  opcode_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int hp = 4;

    spi_flash_responder dut (
        .clk(clk), .rst(rst), .csn(csn), .sck(sck), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .opcode_o(opcode_o), .cmd_done(cmd_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cmd_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master shifts n bits MSB first and samples sdo late in each sck-high phase
    task automatic xbits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            sdi = tx[7-i];
            wait_clks(hp);
            sck = 1'b1;
            wait_clks(hp);
            rx[7-i] = sdo;
            sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        xbits(tx, 8, rx);
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] dummy;
        xbits(tx, 8, dummy);
    endtask

    task automatic cs_low();
        csn = 1'b0;
        wait_clks(4);
    endtask

    task automatic cs_high();
        wait_clks(hp);
        csn = 1'b1;
        wait_clks(4);
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        wait_clks(1);
        mem_we    = 1'b0;
    endtask

    task automatic read_status(output logic [7:0] rx);
        cs_low();
        send(8'h05);
        xfer(8'h00, rx);
        cs_high();
    endtask

    task automatic read_byte(input logic [23:0] a, output logic [7:0] rx);
        cs_low();
        send(8'h03);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
        xfer(8'h00, rx);
        cs_high();
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] rdid_exp [4];
        logic [7:0] rd_exp [3];
        int d0;
        rdid_exp = '{8'hEF, 8'h40, 8'h16, 8'h00};
        rd_exp   = '{8'hA5, 8'h5A, 8'h3C};

        wait_clks(3);
        check("rst_sdo", 32'(sdo), 32'h0);
        check("rst_oe", 32'(sdo_oe), 32'h0);
        check("rst_opcode", 32'(opcode_o), 32'h00);
        check("rst_done", 32'(cmd_done), 32'h0);
        rst = 1'b0;
        wait_clks(3);

        // RDID at 8x oversampling
        hp = 4;
        d0 = done_cnt;
        cs_low();
        check("rdid_oe_pre", 32'(sdo_oe), 32'h0);
        send(8'h9F);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, rx);
            check($sformatf("rdid_b%0d", i), 32'(rx), 32'(rdid_exp[i]));
            check($sformatf("rdid_oe%0d", i), 32'(sdo_oe), 32'h1);
        end
        cs_high();
        check("rdid_done", 32'(done_cnt - d0), 32'd1);
        check("rdid_opcode", 32'(opcode_o), 32'h9F);
        check("rdid_oe_post", 32'(sdo_oe), 32'h0);

        // READ across the top of the array
        preload(12'hFFE, 8'hA5);
        preload(12'hFFF, 8'h5A);
        preload(12'h000, 8'h3C);
        cs_low();
        send(8'h03); send(8'h00); send(8'h0F); send(8'hFE);
        for (int i = 0; i < 3; i++) begin
            xfer(8'h00, rx);
            check($sformatf("read_b%0d", i), 32'(rx), 32'(rd_exp[i]));
        end
        cs_high();
        check("read_opcode", 32'(opcode_o), 32'h03);

        // Abort after 5 opcode bits, then RDSR
        d0 = done_cnt;
        cs_low();
        xbits(8'h9F, 5, rx);
        cs_high();
        check("abort_done", 32'(done_cnt - d0), 32'd0);
        check("abort_opcode", 32'(opcode_o), 32'h03);
        d0 = done_cnt;
        read_status(rx);
        check("abort_rdsr", 32'(rx), 32'h00);
        check("abort_rdsr_done", 32'(done_cnt - d0), 32'd1);
        check("abort_rdsr_opcode", 32'(opcode_o), 32'h05);

`ifdef SPI_RESP_PROGRAM_EN
        // Page program with WIP timing at 4x oversampling
        hp = 2;
        preload(12'h1FF, 8'hFF);
        preload(12'h100, 8'hFF);
        cs_low(); send(8'h06); cs_high();
        read_status(rx);
        check("pp_wel", 32'(rx), 32'h02);
        cs_low();
        send(8'h02); send(8'h00); send(8'h01); send(8'hFF);
        send(8'hF0); send(8'h0F);
        cs_high();
        read_status(rx);
        check("pp_wip_set", 32'(rx), 32'h01);
        wait_clks(64);
        read_status(rx);
        check("pp_wip_clr", 32'(rx), 32'h00);
        read_byte(24'h0001FF, rx);
        check("pp_mem_1ff", 32'(rx), 32'hF0);
        read_byte(24'h000100, rx);
        check("pp_mem_100", 32'(rx), 32'h0F);
        hp = 4;
`else
        // WREN is an unknown opcode in this build
        cs_low(); send(8'h06); cs_high();
        read_status(rx);
        check("wren_ignored", 32'(rx), 32'h00);
`endif

        // PP without WREN leaves the array alone
        preload(12'h010, 8'h55);
        cs_low();
        send(8'h02); send(8'h00); send(8'h00); send(8'h10); send(8'h00);
        cs_high();
        read_status(rx);
        check("nowren_rdsr", 32'(rx), 32'h00);
        read_byte(24'h000010, rx);
        check("nowren_mem", 32'(rx), 32'h55);

        // Async reset in the middle of a READ response (0x5A: first bits 0,1)
        cs_low();
        send(8'h03); send(8'h00); send(8'h0F); send(8'hFF);
        xbits(8'h00, 2, rx);
        #1;
        check("rst_mid_bits", 32'(rx[7:6]), 32'h1);
        check("rst_mid_sdo_pre", 32'(sdo), 32'h1);
        check("rst_mid_oe_pre", 32'(sdo_oe), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_mid_sdo", 32'(sdo), 32'h0);
        check("rst_mid_oe", 32'(sdo_oe), 32'h0);
        check("rst_mid_opcode", 32'(opcode_o), 32'h00);
        csn = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(3);
        cs_low();
        send(8'h9F);
        xfer(8'h00, rx);
        cs_high();
        check("post_rst_rdid", 32'(rx), 32'hEF);
        check("post_rst_opcode", 32'(opcode_o), 32'h9F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
